accel_busy_ctrl: RTL and testbench

ACCEL_BUSY_CTRL -- requirements
Module: accel_busy_ctrl

---
 rtl/accel_pkg.sv | 24 ++
 rtl/accel_wdog_cnt.sv | 19 +
 rtl/accel_busy_ctrl.sv | 121 ++++++++++++
 tb/tb_accel_busy_ctrl.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/accel_pkg.sv
// rtl/accel_pkg.sv - shared state encoding and default timeouts for accel_busy_ctrl
package accel_pkg;

  localparam logic [15:0] DEF_FFT_TIMEOUT    = 16'd1024;
  localparam logic [15:0] DEF_CRYPTO_TIMEOUT = 16'd256;

`ifdef ACCEL_TIMEOUT_EN
  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    FFT_WAIT    = 3'd1,
    CRYPTO_WAIT = 3'd2,
    DONE        = 3'd3,
    ERROR       = 3'd4
  } accel_state_e;
`else
  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    FFT_WAIT    = 3'd1,
    CRYPTO_WAIT = 3'd2,
    DONE        = 3'd3
  } accel_state_e;
`endif

endpackage

// File: rtl/accel_wdog_cnt.sv
// rtl/accel_wdog_cnt.sv - 16-bit wait-cycle counter, zero outside WAIT so it is 0 on every WAIT entry
module accel_wdog_cnt (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  output logic [15:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= 16'd0;
    end else if (run) begin
      count <= count + 16'd1;
    end else begin
      count <= 16'd0;
    end
  end

endmodule

// File: rtl/accel_busy_ctrl.sv
// rtl/accel_busy_ctrl.sv - accelerator busy/stall controller; timeout watchdog enabled by ACCEL_TIMEOUT_EN
module accel_busy_ctrl
  import accel_pkg::*;
#(
  parameter logic [15:0] FFT_TIMEOUT    = DEF_FFT_TIMEOUT,
  parameter logic [15:0] CRYPTO_TIMEOUT = DEF_CRYPTO_TIMEOUT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic issue_fft,
  input  logic issue_crypto,
  input  logic fft_done,
  input  logic crypto_done,
  input  logic exc_ack,
  output logic fft_start,
  output logic crypto_start,
  output logic fft,
  output logic crypto,
  output logic exception,
  output logic wb_valid
);

  accel_state_e state_q, state_d;
  logic fft_start_d, crypto_start_d;
  logic fft_expired, crypto_expired;

`ifdef ACCEL_TIMEOUT_EN
  logic [15:0] wait_cnt;
  logic        in_wait;

  assign in_wait = (state_q == FFT_WAIT) || (state_q == CRYPTO_WAIT);

  accel_wdog_cnt u_wdog (
    .clk   (clk),
    .rst_n (rst_n),
    .run   (in_wait),
    .count (wait_cnt)
  );

  assign fft_expired    = (wait_cnt == FFT_TIMEOUT - 16'd1);
  assign crypto_expired = (wait_cnt == CRYPTO_TIMEOUT - 16'd1);
`else
  logic unused_cfg;
  assign unused_cfg     = ^{exc_ack, FFT_TIMEOUT, CRYPTO_TIMEOUT};
  assign fft_expired    = 1'b0;
  assign crypto_expired = 1'b0;
`endif

  always_comb begin
    state_d        = state_q;
    fft_start_d    = 1'b0;
    crypto_start_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (issue_fft) begin
          state_d     = FFT_WAIT;
          fft_start_d = 1'b1;
        end else if (issue_crypto) begin
          state_d        = CRYPTO_WAIT;
          crypto_start_d = 1'b1;
        end
      end
      // done wins over a same-cycle expiry
      FFT_WAIT: begin
        if (fft_done) begin
          state_d = DONE;
        end else if (fft_expired) begin
`ifdef ACCEL_TIMEOUT_EN
          state_d = ERROR;
`endif
        end
      end
      CRYPTO_WAIT: begin
        if (crypto_done) begin
          state_d = DONE;
        end else if (crypto_expired) begin
`ifdef ACCEL_TIMEOUT_EN
          state_d = ERROR;
`endif
        end
      end
      DONE: state_d = IDLE;
`ifdef ACCEL_TIMEOUT_EN
      ERROR: if (exc_ack) state_d = IDLE;
`endif
      default: state_d = IDLE;
    endcase
  end

  // Outputs are flopped from the next state so they line up with state_q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      fft_start    <= 1'b0;
      crypto_start <= 1'b0;
      fft          <= 1'b0;
      crypto       <= 1'b0;
      wb_valid     <= 1'b0;
    end else begin
      state_q      <= state_d;
      fft_start    <= fft_start_d;
      crypto_start <= crypto_start_d;
      fft          <= (state_d == FFT_WAIT);
      crypto       <= (state_d == CRYPTO_WAIT);
      wb_valid     <= (state_d == DONE);
    end
  end

`ifdef ACCEL_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exception <= 1'b0;
    end else begin
      exception <= (state_d == ERROR);
    end
  end
`else
  assign exception = 1'b0;
`endif

endmodule

// File: tb/tb_accel_busy_ctrl.sv
// tb/tb_accel_busy_ctrl.sv - scoreboard bench for accel_busy_ctrl (timeout cases follow ACCEL_TIMEOUT_EN)
module tb_accel_busy_ctrl;

  // expected vector layout: {fft_start, crypto_start, fft, crypto, exception, wb_valid}
  localparam logic [5:0] Z   = 6'b000000;
  localparam logic [5:0] FS  = 6'b100000;
  localparam logic [5:0] CS  = 6'b010000;
  localparam logic [5:0] F   = 6'b001000;
  localparam logic [5:0] C   = 6'b000100;
  localparam logic [5:0] EX  = 6'b000010;
  localparam logic [5:0] WB  = 6'b000001;

  typedef struct {
    string      name;
    logic [5:0] val;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic issue_fft = 1'b0, issue_crypto = 1'b0, fft_done = 1'b0, crypto_done = 1'b0, exc_ack = 1'b0;
  logic fft_start, crypto_start, fft, crypto, exception, wb_valid;

  exp_t exp_q[$];
  int   compared = 0;
  int   mismatched = 0;

  accel_busy_ctrl #(
    .FFT_TIMEOUT    (16'd1024),
    .CRYPTO_TIMEOUT (16'd4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .issue_fft    (issue_fft),
    .issue_crypto (issue_crypto),
    .fft_done     (fft_done),
    .crypto_done  (crypto_done),
    .exc_ack      (exc_ack),
    .fft_start    (fft_start),
    .crypto_start (crypto_start),
    .fft          (fft),
    .crypto       (crypto),
    .exception    (exception),
    .wb_valid     (wb_valid)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    exp_t       e;
    logic [5:0] act;
    if (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      act = {fft_start, crypto_start, fft, crypto, exception, wb_valid};
      compared++;
      if (act !== e.val) begin
        mismatched++;
        $display("FAIL %s: outputs=%b expected=%b", e.name, act, e.val);
      end
    end
  end

  // One cycle: push the outputs expected in this cycle, then drive this cycle's inputs.
  task automatic step(input string nm, input logic rn, input logic ifft, input logic icr,
                      input logic fd, input logic cd, input logic ack, input logic [5:0] ev);
    @(posedge clk);
    #1;
    exp_q.push_back('{nm, ev});
    rst_n        = rn;
    issue_fft    = ifft;
    issue_crypto = icr;
    fft_done     = fd;
    crypto_done  = cd;
    exc_ack      = ack;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
    $fatal(1);
  end

  initial begin
    step("reset0", 1'b0, 0, 0, 0, 0, 0, Z);
    step("reset1", 1'b0, 0, 0, 0, 0, 0, Z);
    step("release", 1'b1, 0, 0, 0, 0, 0, Z);

    // issue at cycle 0, done at cycle 5
    step("fft_c0", 1'b1, 1, 0, 0, 0, 0, Z);
    step("fft_c1", 1'b1, 0, 0, 0, 0, 0, FS | F);
    step("fft_c2", 1'b1, 0, 0, 0, 0, 0, F);
    step("fft_c3", 1'b1, 0, 0, 0, 0, 0, F);
    step("fft_c4", 1'b1, 0, 0, 0, 0, 0, F);
    step("fft_c5", 1'b1, 0, 0, 1, 0, 0, F);
    step("fft_c6", 1'b1, 0, 0, 0, 0, 0, WB);
    step("fft_c7", 1'b1, 0, 0, 0, 0, 0, Z);

    step("both_c0", 1'b1, 1, 1, 0, 0, 0, Z);
    step("both_c1", 1'b1, 0, 0, 0, 0, 0, FS | F);
    step("both_c2", 1'b1, 0, 0, 1, 0, 0, F);
    step("both_c3", 1'b1, 0, 0, 0, 0, 0, WB);
    step("both_c4", 1'b1, 0, 0, 0, 0, 0, Z);

    // crypto issue and crypto_done while in FFT_WAIT are ignored
    step("ign_c0", 1'b1, 1, 0, 0, 0, 0, Z);
    step("ign_c1", 1'b1, 0, 1, 0, 0, 0, FS | F);
    step("ign_c2", 1'b1, 0, 1, 0, 1, 0, F);
    step("ign_c3", 1'b1, 0, 0, 1, 0, 0, F);
    step("ign_c4", 1'b1, 0, 0, 0, 0, 0, WB);
    step("ign_c5", 1'b1, 0, 0, 0, 0, 0, Z);

    step("cry_c0", 1'b1, 0, 1, 0, 0, 0, Z);
    step("cry_c1", 1'b1, 0, 0, 0, 0, 0, CS | C);
    step("cry_c2", 1'b1, 0, 0, 0, 1, 0, C);
    step("cry_c3", 1'b1, 0, 0, 0, 0, 0, WB);
    step("cry_c4", 1'b1, 0, 0, 0, 0, 0, Z);

    // no done: four WAIT cycles then ERROR when the watchdog is built in
    step("tmo_c0", 1'b1, 0, 1, 0, 0, 0, Z);
    step("tmo_c1", 1'b1, 0, 0, 0, 0, 0, CS | C);
    step("tmo_c2", 1'b1, 0, 0, 0, 0, 0, C);
    step("tmo_c3", 1'b1, 0, 0, 0, 0, 0, C);
    step("tmo_c4", 1'b1, 0, 0, 0, 0, 0, C);
`ifdef ACCEL_TIMEOUT_EN
    step("tmo_c5", 1'b1, 0, 0, 0, 0, 0, EX);
    step("tmo_c6", 1'b1, 1, 0, 0, 0, 0, EX);
    step("tmo_c7", 1'b1, 0, 0, 0, 0, 1, EX);
    step("tmo_c8", 1'b1, 0, 0, 0, 0, 0, Z);
`else
    step("tmo_c5", 1'b1, 0, 0, 0, 0, 1, C);
    step("tmo_c6", 1'b1, 1, 0, 0, 0, 0, C);
    step("tmo_c7", 1'b1, 0, 0, 0, 1, 0, C);
    step("tmo_c8", 1'b1, 0, 0, 0, 0, 0, WB);
    step("tmo_c9", 1'b1, 0, 0, 0, 0, 0, Z);
`endif

    // done on the expiry cycle wins
    step("exp_c0", 1'b1, 0, 1, 0, 0, 0, Z);
    step("exp_c1", 1'b1, 0, 0, 0, 0, 0, CS | C);
    step("exp_c2", 1'b1, 0, 0, 0, 0, 0, C);
    step("exp_c3", 1'b1, 0, 0, 0, 0, 0, C);
    step("exp_c4", 1'b1, 0, 0, 0, 1, 0, C);
    step("exp_c5", 1'b1, 0, 0, 0, 0, 0, WB);
    step("exp_c6", 1'b1, 0, 0, 0, 0, 0, Z);

    // reset dropped mid-cycle in FFT_WAIT; outputs checked later in that same cycle
    step("rst_c0", 1'b1, 1, 0, 0, 0, 0, Z);
    step("rst_c1", 1'b1, 0, 0, 0, 0, 0, FS | F);
    step("rst_c2", 1'b0, 0, 0, 0, 0, 0, Z);
    step("rst_c3", 1'b0, 0, 0, 0, 0, 0, Z);
    step("rst_c4", 1'b1, 0, 0, 0, 0, 0, Z);
    step("rst_c5", 1'b1, 0, 0, 1, 0, 0, Z);
    step("rst_c6", 1'b1, 0, 0, 0, 0, 0, Z);
    step("rst_c7", 1'b1, 0, 0, 0, 0, 0, Z);

    repeat (4) @(posedge clk);
    compared++;
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL drain: pending=%0d expected=0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
